mem_stream_reader: RTL and testbench

- Read-side initiator for one port of the team's synchronous-read true dual-port RAM (1-cycle read latency, read-first).
- On `start`, issues `len` sequential reads from `base_addr` and delivers the words as a valid/ready stream, with a last-beat marker.
- Absorbs the RAM's fixed read latency against downstream backpressure with a 2-entry buffer.
- Used by the DMA path to drain compute results out of local memory.

---
 rtl/mem_stream_pkg.sv | 26 ++
 rtl/sync_fifo2.sv | 57 +++++
 rtl/mem_stream_reader.sv | 111 +++++++++++
 tb/tb_mem_stream_reader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory stream reader and its skid FIFO.
// Occupancy helper lets the issue logic and the FIFO agree on one credit rule.
package mem_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [FIFO_CNT_W-1:0] cnt_t;
  typedef logic [FIFO_CNT_W:0]   occ_t;

  // A read may be issued only if the word it returns is guaranteed a slot
  // once this cycle's pop (if any) has retired.
  function automatic logic credit_ok(input cnt_t count, input logic inflight,
                                     input logic pop);
    occ_t occ;
    occ = occ_t'(count) + occ_t'(inflight);
    return occ < (occ_t'(FIFO_DEPTH) + occ_t'(pop));
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry register FIFO with a combinational head; absorbs the RAM read
// latency so the stream can stall without losing in-flight words.
module sync_fifo2
  import mem_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output cnt_t             count_o,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  cnt_t             count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset on purpose so the stream data output comes
      // up as zero; a larger RAM-style array would be left unreset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      // Push and pop together leave the count unchanged, even when full:
      // the popped slot is the one being overwritten.
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && count_q == cnt_t'(FIFO_DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && count_q == '0));

endmodule

// File: rtl/mem_stream_reader.sv
// Reads len sequential words from a 1-cycle-latency RAM port starting at
// base_addr and presents them as a valid/ready stream with a last marker.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  issue_rem_q;
  logic [LEN_WIDTH-1:0]  beat_rem_q;
  logic                  inflight_q;

  cnt_t                  fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_empty;
  logic                  pop;
  logic                  issue;
  logic                  last_beat;

  assign pop       = m_valid & m_ready;
  assign last_beat = (beat_rem_q == LEN_WIDTH'(1));

  always_comb begin
    // NOTE: default first so every path assigns issue and no latch is inferred.
    issue = 1'b0;
    if (state_q == RUN && issue_rem_q != '0)
      issue = credit_ok(fifo_count, inflight_q, pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_rem_q <= '0;
      beat_rem_q  <= '0;
      inflight_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register sees the
      // pre-edge values of its peers regardless of statement order.
      inflight_q <= issue;
      if (issue) begin
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        issue_rem_q <= issue_rem_q - LEN_WIDTH'(1);
      end
      if (pop) beat_rem_q <= beat_rem_q - LEN_WIDTH'(1);

      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q      <= base_addr;
            issue_rem_q <= len;
            beat_rem_q  <= len;
            state_q     <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (pop && last_beat) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The RAM captures mem_dout one cycle after each issue; that word is
  // always pushed, the credit check having reserved its slot already.
  sync_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .din_i   (mem_dout),
    .pop_i   (pop),
    .count_o (fifo_count),
    .head_o  (fifo_head),
    .empty_o (fifo_empty)
  );

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign mem_en   = issue;
  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;
  assign mem_din  = '0;
  assign m_valid  = ~fifo_empty;
  assign m_data   = fifo_head;
  assign m_last   = m_valid & last_beat;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader against a behavioural 1-cycle RAM
// preloaded with mem[a] = a + 0x100.
module tb_mem_stream_reader;

  localparam int DW = 32;
  localparam int AW = 13;
  localparam int LW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy, done, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  mem_stream_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) if (mem_en) mem_dout <= ram[mem_addr];

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  logic [AW-1:0] addr_seen [$];
  int done_cnt, done_cyc, busy_cnt, stall_viol, occ_viol;
  bit timed_out;
  bit rdy_pat [16] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer cycle by cycle, recording what the DUT did; the test
  // tasks decide what was expected.
  task automatic do_transfer(input logic [AW-1:0] b, input logic [LW-1:0] n,
                             input bit use_bp, input int restart_at);
    int issued, popped;
    bit prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;
    got_data.delete();
    got_last.delete();
    addr_seen.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; stall_viol = 0; occ_viol = 0;
    timed_out = 1'b1;
    issued = 0; popped = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    start = 1'b1; base_addr = b; len = n;
    for (int c = 0; c <= 80; c++) begin
      if (c > 0) begin
        start = (c == restart_at);
        if (c == restart_at) begin
          base_addr = 13'h0500;
          len       = 14'd7;
        end
      end
      m_ready = use_bp ? rdy_pat[c % 16] : 1'b1;
      #1;
      if (issued - popped > 2) occ_viol++;
      if (mem_en) begin
        addr_seen.push_back(mem_addr);
        issued++;
      end
      if (prev_stall && !m_valid) stall_viol++;
      if (m_valid) begin
        if (prev_stall && (m_data !== prev_data || m_last !== prev_last)) stall_viol++;
        if (m_ready) begin
          got_data.push_back(m_data);
          got_last.push_back(m_last);
          popped++;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      tick;
      if (done_cyc >= 0 && c >= done_cyc + 2) begin
        timed_out = 1'b0;
        break;
      end
    end
    start   = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset;
    logic [52:0] obs;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    #12;
    obs = {busy, done, mem_en, mem_addr, m_valid, m_last, m_data, mem_we, mem_din == '0};
    vectors++;
    if (obs !== {1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_values got=%h exp=%h", obs,
               {1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1});
    end
    #10 rst_n = 1'b1;
    tick;
  endtask

  // Exact cycle timeline: issues c1..c4, beats c3..c6, done c7.
  task automatic test_basic;
    logic [49:0] exp_t [9];
    logic [49:0] obs;
    exp_t[0] = {1'b0, 13'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0};
    exp_t[1] = {1'b1, 13'h010, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0};
    exp_t[2] = {1'b1, 13'h011, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0};
    exp_t[3] = {1'b1, 13'h012, 1'b1, 32'h110, 1'b0, 1'b1, 1'b0};
    exp_t[4] = {1'b1, 13'h013, 1'b1, 32'h111, 1'b0, 1'b1, 1'b0};
    exp_t[5] = {1'b0, 13'h000, 1'b1, 32'h112, 1'b0, 1'b1, 1'b0};
    exp_t[6] = {1'b0, 13'h000, 1'b1, 32'h113, 1'b1, 1'b1, 1'b0};
    exp_t[7] = {1'b0, 13'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b1};
    exp_t[8] = {1'b0, 13'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0};
    start = 1'b1; base_addr = 13'h010; len = 14'd4; m_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) start = 1'b0;
      #1;
      obs = {mem_en, mem_en ? mem_addr : 13'h0, m_valid, m_valid ? m_data : 32'h0,
             m_last, busy, done};
      vectors++;
      if (obs !== exp_t[c]) begin
        miscompares++;
        $display("FAIL basic_c%0d got=%h exp=%h", c, obs, exp_t[c]);
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] act;
    do_transfer(13'h010, 14'd4, 1'b1, -1);
    vectors++;
    if (timed_out !== 1'b0) begin miscompares++; $display("FAIL bp_timeout got=%0d exp=0", timed_out); end
    vectors++;
    if (got_data.size() != 4) begin miscompares++; $display("FAIL bp_beat_count got=%0d exp=4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      act = (i < got_data.size()) ? got_data[i] : 'x;
      vectors++;
      if (act !== 32'h110 + 32'(i)) begin
        miscompares++;
        $display("FAIL bp_data%0d got=%h exp=%h", i, act, 32'h110 + 32'(i));
      end
      vectors++;
      if (i < got_last.size() && got_last[i] !== (i == 3)) begin
        miscompares++;
        $display("FAIL bp_last%0d got=%b exp=%b", i, got_last[i], i == 3);
      end
    end
    vectors++;
    if (stall_viol != 0) begin miscompares++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
    vectors++;
    if (occ_viol != 0) begin miscompares++; $display("FAIL bp_occupancy got=%0d exp=0", occ_viol); end
    vectors++;
    if (addr_seen.size() != 4) begin miscompares++; $display("FAIL bp_issue_count got=%0d exp=4", addr_seen.size()); end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] exp_d [4];
    logic [AW-1:0] act_a;
    logic [DW-1:0] act_d;
    exp_a = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    exp_d = '{32'h20FE, 32'h20FF, 32'h0100, 32'h0101};
    do_transfer(13'h1FFE, 14'd4, 1'b0, -1);
    vectors++;
    if (timed_out !== 1'b0) begin miscompares++; $display("FAIL wrap_timeout got=%0d exp=0", timed_out); end
    for (int i = 0; i < 4; i++) begin
      act_a = (i < addr_seen.size()) ? addr_seen[i] : 'x;
      act_d = (i < got_data.size()) ? got_data[i] : 'x;
      vectors++;
      if (act_a !== exp_a[i]) begin miscompares++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, act_a, exp_a[i]); end
      vectors++;
      if (act_d !== exp_d[i]) begin miscompares++; $display("FAIL wrap_data%0d got=%h exp=%h", i, act_d, exp_d[i]); end
    end
  endtask

  task automatic test_len_zero;
    do_transfer(13'h0040, 14'd0, 1'b0, -1);
    vectors++;
    if (timed_out !== 1'b0) begin miscompares++; $display("FAIL len0_timeout got=%0d exp=0", timed_out); end
    vectors++;
    if (addr_seen.size() != 0) begin miscompares++; $display("FAIL len0_mem_en got=%0d exp=0", addr_seen.size()); end
    vectors++;
    if (got_data.size() != 0) begin miscompares++; $display("FAIL len0_valid got=%0d exp=0", got_data.size()); end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL len0_done_count got=%0d exp=1", done_cnt); end
    vectors++;
    if (done_cyc < 1 || done_cyc > 2) begin miscompares++; $display("FAIL len0_done_cycle got=%0d exp=1..2", done_cyc); end
    vectors++;
    if (busy_cnt != 0) begin miscompares++; $display("FAIL len0_busy got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_restart_ignored;
    logic [AW-1:0] act_a;
    logic [DW-1:0] act_d;
    do_transfer(13'h010, 14'd4, 1'b0, 2);
    vectors++;
    if (addr_seen.size() != 4 || got_data.size() != 4) begin
      miscompares++;
      $display("FAIL restart_counts got=%0d/%0d exp=4/4", addr_seen.size(), got_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      act_a = (i < addr_seen.size()) ? addr_seen[i] : 'x;
      act_d = (i < got_data.size()) ? got_data[i] : 'x;
      vectors++;
      if (act_a !== 13'h010 + 13'(i)) begin miscompares++; $display("FAIL restart_addr%0d got=%h exp=%h", i, act_a, 13'h010 + 13'(i)); end
      vectors++;
      if (act_d !== 32'h110 + 32'(i)) begin miscompares++; $display("FAIL restart_data%0d got=%h exp=%h", i, act_d, 32'h110 + 32'(i)); end
    end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [52:0] obs;
    start = 1'b1; base_addr = 13'h020; len = 14'd6; m_ready = 1'b0;
    tick;
    start = 1'b0;
    tick; tick; tick;
    #1;
    vectors++;
    if ({busy, m_valid, m_data} !== {1'b1, 1'b1, 32'h120}) begin
      miscompares++;
      $display("FAIL midrst_pre got=%h exp=%h", {busy, m_valid, m_data}, {1'b1, 1'b1, 32'h120});
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {busy, done, mem_en, mem_addr, m_valid, m_last, m_data, mem_we, mem_din == '0};
    vectors++;
    if (obs !== {1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_values got=%h exp=%h", obs,
               {1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1});
    end
    #2 rst_n = 1'b1;
    m_ready = 1'b1;
    tick;
    do_transfer(13'h030, 14'd2, 1'b0, -1);
    vectors++;
    if (got_data.size() != 2) begin miscompares++; $display("FAIL midrst_beats got=%0d exp=2", got_data.size()); end
    else begin
      vectors++;
      if ({got_data[0], got_data[1]} !== {32'h130, 32'h131}) begin
        miscompares++;
        $display("FAIL midrst_data got=%h %h exp=130 131", got_data[0], got_data[1]);
      end
      vectors++;
      if ({got_last[0], got_last[1]} !== 2'b01) begin
        miscompares++;
        $display("FAIL midrst_last got=%b%b exp=01", got_last[0], got_last[1]);
      end
    end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL midrst_done_count got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    for (int a = 0; a < 2**AW; a++) ram[a] = 32'h100 + 32'(a);
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_len_zero;
    test_restart_ignored;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
